// File: rtl/osd_pkg.sv
// Shared definitions for the on-screen number writer.
//   state_e     : top-level FSM state encoding
//   Ascii*      : character codes emitted into the character RAM
//   BcdDigits   : BCD digits held by the converter (enough for a 32-bit value)
//   digit_char  : maps a 4-bit digit value to '0'..'9' / 'A'..'F'
package osd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StWrite,
    StDone
  } state_e;

  localparam logic [7:0] AsciiSpace = 8'h20;
  localparam logic [7:0] AsciiPlus  = 8'h2B;
  localparam logic [7:0] AsciiMinus = 8'h2D;
  localparam logic [7:0] AsciiHash  = 8'h23;
  localparam logic [7:0] AsciiZero  = 8'h30;
  localparam logic [7:0] AsciiA     = 8'h41;

  localparam int unsigned BcdDigits = 10;

  function automatic logic [7:0] digit_char(input logic [3:0] v);
    if (v < 4'd10) begin
      return AsciiZero + {4'h0, v};
    end
    return AsciiA + {4'h0, v} - 8'd10;
  endfunction

endpackage

// File: rtl/num_to_ascii_writer_if.sv
// Request / character-RAM write bundle of num_to_ascii_writer.
//   start, value, is_signed, hex_mode, blank_zeros, base_addr : request (master -> slave)
//   wr_en, wr_addr, wr_data                                   : character RAM write port
//   busy, done, overflow                                      : status
interface num_to_ascii_writer_if #(
  parameter int unsigned VALUE_W = 16,
  parameter int unsigned ADDR_W  = 11
);

  logic               start;
  logic [VALUE_W-1:0] value;
  logic               is_signed;
  logic               hex_mode;
  logic               blank_zeros;
  logic [ADDR_W-1:0]  base_addr;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [7:0]         wr_data;
  logic               busy;
  logic               done;
  logic               overflow;

  modport master (
    output start, value, is_signed, hex_mode, blank_zeros, base_addr,
    input  wr_en, wr_addr, wr_data, busy, done, overflow
  );

  modport slave (
    input  start, value, is_signed, hex_mode, blank_zeros, base_addr,
    output wr_en, wr_addr, wr_data, busy, done, overflow
  );

endinterface

// File: rtl/osd_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
//   clk_i, reset_i : clock, synchronous active-high reset
//   start_i, bin_i : load bin_i and begin a VALUE_W-cycle conversion
//   done_o         : high during the final conversion cycle; bcd_o holds the
//                    result from the following edge until the next start_i
//   bcd_o          : BcdDigits packed BCD digits, least significant in [3:0]
//   overflow_o     : result needs more than DIGITS decimal digits
module osd_bcd_seq
  import osd_pkg::*;
#(
  parameter int unsigned VALUE_W = 16,
  parameter int unsigned DIGITS  = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [VALUE_W-1:0]     bin_i,
  output logic                   done_o,
  output logic [4*BcdDigits-1:0] bcd_o,
  output logic                   overflow_o
);

  localparam int unsigned BcdW = 4 * BcdDigits;

  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BcdW-1:0]    bcd_q, bcd_d, adj;
  logic [5:0]         cnt_q, cnt_d;

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    adj   = bcd_q;
    for (int i = 0; i < BcdDigits; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = 6'(VALUE_W);
    end else if (cnt_q != 6'd0) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o     = (cnt_q == 6'd1);
  assign bcd_o      = bcd_q;
  assign overflow_o = (bcd_q >> (4 * DIGITS)) != '0;

endmodule

// File: rtl/num_to_ascii_writer.sv
// Renders a binary number as a fixed-width ASCII field into a character RAM.
//   clk, reset : clock, synchronous active-high reset
//   bus        : request inputs, RAM write port (wr_en/wr_addr/wr_data) and
//                busy/done/overflow status
// The field is an optional sign character followed by DIGITS digits,
// most significant first, written to ascending addresses from base_addr.
module num_to_ascii_writer
  import osd_pkg::*;
#(
  parameter int unsigned VALUE_W   = 16,
  parameter int unsigned DIGITS    = 5,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned SHOW_SIGN = 1
) (
  input logic                  clk,
  input logic                  reset,
  num_to_ascii_writer_if.slave bus
);

  localparam int unsigned Total = DIGITS + SHOW_SIGN;
  localparam int unsigned IdxW  = 4;
  localparam int unsigned BcdW  = 4 * BcdDigits;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Total - 1);
  // Digit weight of write index 0 (the sign slot when a sign is shown).
  localparam logic [IdxW-1:0] TopPos  = IdxW'(DIGITS - 1 + SHOW_SIGN);

  state_e state_q, state_d;

  logic [VALUE_W-1:0] mag_q, mag_d, in_mag;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [IdxW-1:0]    idx_q, idx_d, dpos;
  logic neg_q, neg_d, signed_q, signed_d, hex_q, hex_d;
  logic blank_q, blank_d, seen_nz_q, seen_nz_d;
  logic in_neg, accept, bcd_start, bcd_done, bcd_ovf, hex_ovf, ovf, is_sign;
  logic [BcdW-1:0] bcd;
  logic [63:0]     digit_src;
  logic [3:0]      digit_val;
  logic [7:0]      char;

  // Magnitude in VALUE_W bits: negating the most negative value wraps to
  // exactly 2^(VALUE_W-1), which is the correct unsigned magnitude.
  assign in_neg    = bus.is_signed & bus.value[VALUE_W-1];
  assign in_mag    = in_neg ? (~bus.value + VALUE_W'(1)) : bus.value;
  assign accept    = (state_q == StIdle) & bus.start;
  assign bcd_start = accept & ~bus.hex_mode;

  osd_bcd_seq #(
    .VALUE_W(VALUE_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (bcd_start),
    .bin_i     (in_mag),
    .done_o    (bcd_done),
    .bcd_o     (bcd),
    .overflow_o(bcd_ovf)
  );

  // Character for the current write index.
  always_comb begin
    is_sign   = (SHOW_SIGN != 0) && (idx_q == '0);
    dpos      = TopPos - idx_q;
    digit_src = hex_q ? 64'(mag_q) : 64'(bcd);
    digit_val = 4'(digit_src >> {dpos, 2'b00});
    hex_ovf   = (64'(mag_q) >> (4 * DIGITS)) != 64'd0;
    ovf       = hex_q ? hex_ovf : bcd_ovf;
    if (is_sign) begin
      char = neg_q ? AsciiMinus : (signed_q ? AsciiPlus : AsciiSpace);
    end else if (ovf) begin
      char = AsciiHash;
    end else if (blank_q && !seen_nz_q && (digit_val == 4'd0) && (dpos != '0)) begin
      char = AsciiSpace;
    end else begin
      char = digit_char(digit_val);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StConvert;
      StConvert: if (hex_q || bcd_done) state_d = StWrite;
      StWrite:   if (idx_q == LastIdx) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Request latch and write-index datapath.
  always_comb begin
    mag_d     = mag_q;
    base_d    = base_q;
    idx_d     = idx_q;
    neg_d     = neg_q;
    signed_d  = signed_q;
    hex_d     = hex_q;
    blank_d   = blank_q;
    seen_nz_d = seen_nz_q;
    if (accept) begin
      mag_d     = in_mag;
      base_d    = bus.base_addr;
      idx_d     = '0;
      neg_d     = in_neg;
      signed_d  = bus.is_signed;
      hex_d     = bus.hex_mode;
      blank_d   = bus.blank_zeros;
      seen_nz_d = 1'b0;
    end else if (state_q == StWrite) begin
      idx_d = idx_q + IdxW'(1);
      if (!is_sign && (digit_val != 4'd0)) begin
        seen_nz_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mag_q     <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      neg_q     <= 1'b0;
      signed_q  <= 1'b0;
      hex_q     <= 1'b0;
      blank_q   <= 1'b0;
      seen_nz_q <= 1'b0;
    end else begin
      mag_q     <= mag_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      neg_q     <= neg_d;
      signed_q  <= signed_d;
      hex_q     <= hex_d;
      blank_q   <= blank_d;
      seen_nz_q <= seen_nz_d;
    end
  end

  // Outputs; forced low while reset is high so nothing reaches the RAM then.
  always_comb begin
    bus.wr_en    = ~reset & (state_q == StWrite);
    bus.busy     = ~reset & (state_q != StIdle);
    bus.done     = ~reset & (state_q == StDone);
    bus.overflow = bus.done & ovf;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    if (bus.wr_en) begin
      bus.wr_addr = base_q + ADDR_W'(idx_q);
      bus.wr_data = char;
    end
  end

endmodule

// File: tb/tb_num_to_ascii_writer.sv
// Directed bench for num_to_ascii_writer: default instance plus a DIGITS=4
// instance for the overflow case.
module tb_num_to_ascii_writer;

  logic clk;
  logic reset;

  num_to_ascii_writer_if #(.VALUE_W(16), .ADDR_W(11)) bus ();
  num_to_ascii_writer_if #(.VALUE_W(16), .ADDR_W(11)) bus4 ();

  num_to_ascii_writer #(
    .VALUE_W(16), .DIGITS(5), .ADDR_W(11), .SHOW_SIGN(1)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  num_to_ascii_writer #(
    .VALUE_W(16), .DIGITS(4), .ADDR_W(11), .SHOW_SIGN(1)
  ) u_dut4 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  cap_data[16];
  logic [10:0] cap_addr[16];
  int          n_wr;
  bit          got_done, got_ovf, done_wr_en, done_busy, aborted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit use4, input logic [15:0] val, input bit sgn, input bit hex,
                       input bit blank, input logic [10:0] base, input bit st);
    if (use4) begin
      bus4.start = st; bus4.value = val; bus4.is_signed = sgn;
      bus4.hex_mode = hex; bus4.blank_zeros = blank; bus4.base_addr = base;
    end else begin
      bus.start = st; bus.value = val; bus.is_signed = sgn;
      bus.hex_mode = hex; bus.blank_zeros = blank; bus.base_addr = base;
    end
  endtask

  task automatic sample(input bit use4, output logic en, output logic dn, output logic bsy,
                        output logic ov, output logic [7:0] data, output logic [10:0] addr);
    if (use4) begin
      en = bus4.wr_en; dn = bus4.done; bsy = bus4.busy; ov = bus4.overflow;
      data = bus4.wr_data; addr = bus4.wr_addr;
    end else begin
      en = bus.wr_en; dn = bus.done; bsy = bus.busy; ov = bus.overflow;
      data = bus.wr_data; addr = bus.wr_addr;
    end
  endtask

  // Issue one request and capture writes until done. lat counts edges from the
  // accepting edge to the first edge at which wr_en is high.
  task automatic run(input bit use4, input logic [15:0] val, input bit sgn, input bit hex,
                     input bit blank, input logic [10:0] base, input int pulse_at,
                     input int reset_at, output int lat);
    logic en, dn, bsy, ov;
    logic [7:0] data;
    logic [10:0] addr;
    lat = 0; n_wr = 0; got_done = 0; got_ovf = 0; aborted = 0;
    @(negedge clk);
    drive(use4, val, sgn, hex, blank, base, 1'b1);
    @(negedge clk);
    for (int c = 1; c <= 200; c++) begin
      drive(use4, val, sgn, hex, blank, base, 1'b0);
      sample(use4, en, dn, bsy, ov, data, addr);
      if (en) begin
        if (lat == 0) lat = c;
        if (n_wr < 16) begin
          cap_data[n_wr] = data;
          cap_addr[n_wr] = addr;
        end
        n_wr++;
      end
      if (dn) begin
        got_done = 1; got_ovf = ov; done_wr_en = en; done_busy = bsy;
        break;
      end
      if (reset_at > 0 && n_wr == reset_at) begin
        aborted = 1;
        break;
      end
      if (pulse_at > 0 && n_wr == pulse_at) drive(use4, 16'hFFFF, 1, 1, 1, 11'h000, 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic check_field(input string tag, input string exp, input logic [10:0] base);
    check({tag, "_count"}, n_wr, exp.len());
    for (int i = 0; i < exp.len() && i < n_wr && i < 16; i++) begin
      check($sformatf("%s_data%0d", tag, i), cap_data[i], exp[i]);
      check($sformatf("%s_addr%0d", tag, i), cap_addr[i], 11'(base + 11'(i)));
    end
  endtask

  task automatic check_idle(input string tag, input bit use4);
    @(negedge clk);
    check(tag, use4 ? bus4.busy : bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int extra;
    reset = 1'b1;
    drive(0, 16'h0, 0, 0, 0, 11'h0, 0);
    drive(1, 16'h0, 0, 0, 0, 11'h0, 0);
    repeat (3) @(negedge clk);
    check("rst_outputs",
          {bus.wr_en, bus.busy, bus.done, bus.overflow, bus.wr_addr, bus.wr_data}, 32'h0);
    check("rst_outputs4",
          {bus4.wr_en, bus4.busy, bus4.done, bus4.overflow, bus4.wr_addr, bus4.wr_data}, 32'h0);
    reset = 1'b0;

    // Signed decimal -1234
    run(0, 16'hFB2E, 1, 0, 0, 11'h100, 0, 0, lat);
    check("dec_neg_latency", lat, 17);
    check_field("dec_neg", "-01234", 11'h100);
    check("dec_neg_done", got_done, 1'b1);
    check("dec_neg_ovf", got_ovf, 1'b0);
    check("done_wr_en", done_wr_en, 1'b0);
    check("done_busy", done_busy, 1'b1);
    check_idle("dec_neg_idle", 0);

    // Unsigned hex 0xBEEF, leading zeros blanked
    run(0, 16'hBEEF, 0, 1, 1, 11'h200, 0, 0, lat);
    check("hex_latency", lat, 2);
    check_field("hex", "  BEEF", 11'h200);
    check("hex_done", got_done, 1'b1);
    check("hex_ovf", got_ovf, 1'b0);

    // Most negative value
    run(0, 16'h8000, 1, 0, 0, 11'h010, 0, 0, lat);
    check_field("min_neg", "-32768", 11'h010);
    check("min_neg_ovf", got_ovf, 1'b0);

    // Signed zero, blanked
    run(0, 16'h0000, 1, 0, 1, 11'h020, 0, 0, lat);
    check_field("zero", "+    0", 11'h020);

    // DIGITS=4 instance overflow
    run(1, 16'd12345, 1, 0, 0, 11'h040, 0, 0, lat);
    check("ovf_latency", lat, 17);
    check_field("ovf", "+####", 11'h040);
    check("ovf_done", got_done, 1'b1);
    check("ovf_flag", got_ovf, 1'b1);
    check_idle("ovf_idle", 1);

    // Address wrap at top of an 11-bit space
    run(0, 16'd42, 0, 0, 0, 11'h7FE, 0, 0, lat);
    check_field("wrap", " 00042", 11'h7FE);

    // Start pulsed during WRITE is ignored
    run(0, 16'h1234, 0, 1, 0, 11'h300, 3, 0, lat);
    check_field("pulse", " 01234", 11'h300);
    check("pulse_done", got_done, 1'b1);
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.wr_en || bus.busy) extra++;
    end
    check("pulse_no_restart", extra, 0);

    // Reset after the second write aborts the field
    run(0, 16'h1234, 0, 1, 0, 11'h400, 0, 2, lat);
    check("abort_reached", aborted, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_wr_en", bus.wr_en, 1'b0);
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.wr_en || bus.done) extra++;
    end
    check("abort_no_more", extra, 0);
    check_field("abort", " 0", 11'h400);

    // Reset wins over a simultaneous start
    @(negedge clk);
    reset = 1'b1;
    drive(0, 16'h0005, 0, 1, 0, 11'h000, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 16'h0005, 0, 1, 0, 11'h000, 1'b0);
    #1;
    check("rst_prio_busy", bus.busy, 1'b0);
    @(negedge clk);
    check("rst_prio_wr_en", bus.wr_en, 1'b0);

    // Back-to-back request still works after all of the above
    run(0, 16'h0007, 1, 0, 1, 11'h500, 0, 0, lat);
    check_field("after", "+    7", 11'h500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/num_to_ascii_writer.md
NUM_TO_ASCII_WRITER -- requirements
Module: num_to_ascii_writer

Interface
REQ-001 SHALL have parameter VALUE_W, default 16, meaning input value width in bits (4..32).
REQ-002 SHALL have parameter DIGITS, default 5, meaning number of digit characters in the field (1..10).
REQ-003 SHALL have parameter ADDR_W, default 11, meaning character RAM address width.
REQ-004 SHALL have parameter SHOW_SIGN, default 1, meaning a sign character precedes the digits.
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to convert and write.
REQ-008 SHALL have port value, input, VALUE_W, number to render.
REQ-009 SHALL have port is_signed, input, 1, value is two's complement when 1.
REQ-010 SHALL have port hex_mode, input, 1, radix 16 when 1, radix 10 when 0.
REQ-011 SHALL have port blank_zeros, input, 1, leading zeros rendered as space when 1.
REQ-012 SHALL have port base_addr, input, ADDR_W, character RAM address of the first field character.
REQ-013 SHALL have ports wr_en (output, 1), wr_addr (output, ADDR_W) and wr_data (output, 8), the character RAM write port.
REQ-014 SHALL have ports busy (output, 1), high while not IDLE; done (output, 1), one-cycle completion pulse; overflow (output, 1), valid with done.

Function
REQ-015 SHALL accept start only in IDLE, latching value, is_signed, hex_mode, blank_zeros and base_addr; start SHALL be ignored while busy.
REQ-016 SHALL use states IDLE -> CONVERT -> WRITE -> DONE -> IDLE.
REQ-017 SHALL compute magnitude as an unsigned VALUE_W-bit quantity; -2^(VALUE_W-1) SHALL yield magnitude 2^(VALUE_W-1) without error.
REQ-018 Decimal CONVERT SHALL use sequential shift-add-3, taking exactly VALUE_W cycles; hex CONVERT SHALL take exactly 1 cycle.
REQ-019 First wr_en SHALL occur VALUE_W+1 cycles after the accepting edge in decimal mode and 2 cycles after it in hex mode.
REQ-020 WRITE SHALL issue one character per cycle, wr_en continuously high, addresses base_addr+0, +1, ... ascending, most significant first; total DIGITS+SHOW_SIGN writes.
REQ-021 Sign character: '-' (0x2D) if is_signed and negative; '+' (0x2B) if is_signed and non-negative; space (0x20) if unsigned.
REQ-022 Digit characters: 0x30..0x39 for 0-9 and 0x41..0x46 for A-F.
REQ-023 With blank_zeros=1, zeros before the first non-zero digit SHALL be 0x20; the least significant digit SHALL always be a digit.
REQ-024 If magnitude exceeds 10^DIGITS-1 (decimal) or 16^DIGITS-1 (hex), every digit position SHALL be '#' (0x23), the sign SHALL be written normally, and overflow SHALL be 1 with done.
REQ-025 wr_addr SHALL wrap modulo 2^ADDR_W.
REQ-026 DONE SHALL last one cycle with done=1, busy=1 and wr_en=0; start SHALL be acceptable in the following cycle.
REQ-027 wr_en SHALL be 0 in IDLE, CONVERT and DONE.

Reset
REQ-028 While reset is high, state SHALL be IDLE and wr_en, wr_addr, wr_data, busy, done and overflow SHALL all be 0.
REQ-029 Reset mid-operation SHALL abort the operation: no further wr_en, no done pulse, busy 0 in the cycle after reset is sampled.
REQ-030 Reset SHALL take priority over a simultaneous start.

Structure
REQ-031 The state enum and the ASCII constants (space, plus, minus, hash, '0', 'A') SHALL live in shared package osd_pkg.
REQ-032 Sequential binary-to-BCD conversion SHALL be a sub-module osd_bcd_seq, parametrised by VALUE_W and DIGITS, with start/done handshake and an overflow output.

Verification (VALUE_W=16, DIGITS=5, SHOW_SIGN=1 unless stated)
REQ-033 Signed decimal -1234, blank_zeros=0, base 0x100 -> '-','0','1','2','3','4' at 0x100..0x105, done, overflow=0, first wr_en 17 cycles after start.
REQ-034 Unsigned hex 0xBEEF, blank_zeros=1 -> ' ',' ','B','E','E','F', first wr_en 2 cycles after start.
REQ-035 Signed decimal -32768 -> '-','3','2','7','6','8'; signed 0 with blank_zeros=1 -> '+',' ',' ',' ',' ','0'.
REQ-036 DIGITS=4 instance, signed decimal 12345 -> '+','#','#','#','#', overflow=1 with done.
REQ-037 base_addr 0x7FE, ADDR_W=11 -> writes at 0x7FE, 0x7FF, 0x000..0x003.
REQ-038 Start pulsed during WRITE -> ignored, field unchanged; reset asserted after second write -> no further wr_en, no done, busy 0 next cycle.
